// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its pending-write scoreboard.
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 6;

    // Architectural index of the hardwired zero register.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy bits for destinations with an outstanding write, plus their count.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    wr,
    input  logic                 issue,
    input  logic [ADDR_W-1:0]    issue_addr,
    input  logic                 flush,
    output logic [2**ADDR_W-1:0] busy,
    output logic [ADDR_W:0]      busy_count
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_nxt;
    logic [ADDR_W:0]  cnt_nxt;
    logic             issue_ok;

    assign issue_ok = issue &&
        !((ZERO_REG != 0) && (issue_addr == ADDR_W'(REG_ZERO)));

    // Issue is applied last so a new producer wins over writeback and flush.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else if (we) begin
            busy_nxt[wr] = 1'b0;
        end
        if (issue_ok) begin
            busy_nxt[issue_addr] = 1'b1;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read / one-write register file with bypass and hazard scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] R1,
    input  logic [ADDR_W-1:0] R2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              RD1_busy,
    output logic              RD2_busy,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WR,
    input  logic [DATA_W-1:0] WD,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              flush,
    output logic [ADDR_W:0]   busy_count
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic ZR  = (ZERO_REG != 0);
    localparam logic BP  = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] A0 = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_ok;
    logic              fwd1, fwd2;
    logic              z1, z2;

    assign wr_ok = RegWrite && !(ZR && (WR == A0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[WR] <= WD;
        end
    end

    assign fwd1 = BP && RegWrite && (WR == R1);
    assign fwd2 = BP && RegWrite && (WR == R2);
    assign z1   = ZR && (R1 == A0);
    assign z2   = ZR && (R2 == A0);

    always_comb begin
        RD1 = mem[R1];
        if (fwd1) RD1 = WD;
        if (z1)   RD1 = '0;
    end

    always_comb begin
        RD2 = mem[R2];
        if (fwd2) RD2 = WD;
        if (z2)   RD2 = '0;
    end

    // A forwarded operand is already resolved, so it is not a hazard.
    assign RD1_busy = busy[R1] && !fwd1 && !z1;
    assign RD2_busy = busy[R2] && !fwd2 && !z2;

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (RegWrite),
        .wr         (WR),
        .issue      (issue),
        .issue_addr (issue_addr),
        .flush      (flush),
        .busy       (busy),
        .busy_count (busy_count)
    );

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-write MIPS register file.
- Provides DEPTH x DATA_W storage with two combinational read ports, one clocked write port, asynchronous clear, optional hardwired zero register and optional write-to-read bypass.
- Adds a per-register pending-write scoreboard (busy bits plus outstanding count) so decode can stall on hazards.
- Sits between decode (reads, issue) and writeback (write) in the pipelined datapath.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 6, register address width; DEPTH = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never marked busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to a matching read port.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- R1  in  ADDR_W  read address, port 1.
- R2  in  ADDR_W  read address, port 2.
- RD1  out  DATA_W  read data, port 1.
- RD2  out  DATA_W  read data, port 2.
- RD1_busy  out  1  R1 has a pending write.
- RD2_busy  out  1  R2 has a pending write.
- RegWrite  in  1  write enable.
- WR  in  ADDR_W  write address.
- WD  in  DATA_W  write data.
- issue  in  1  reserve a destination (set busy).
- issue_addr  in  ADDR_W  destination being reserved.
- flush  in  1  clear all busy bits (pipeline squash).
- busy_count  out  ADDR_W+1  number of registers currently busy.

Behaviour:
- Reset: rst_n low asynchronously clears every register and busy bit, so RD1/RD2 = 0, RDx_busy = 0 and busy_count = 0 while reset is held. A reset asserted mid-operation discards all pending state immediately; there is no partial write.
- Write: on a rising clk edge with RegWrite=1, mem[WR] <= WD. The write is suppressed when ZERO_REG=1 and WR=0.
- Read: combinational, zero latency.
  - RDx = 0 if ZERO_REG and Rx=0.
  - Else RDx = WD if BYPASS and RegWrite and WR=Rx.
  - Else RDx = mem[Rx].
- Read without bypass: with BYPASS=0, a read of the address being written returns the old value until after the edge.
- Scoreboard, per-bit next state at each edge, in priority order:
  1. flush clears all bits.
  2. RegWrite at WR clears busy[WR].
  3. issue at issue_addr sets busy[issue_addr].
- Simultaneous events:
  - Issue and write to the same address: bit ends set (new producer wins).
  - Flush and issue together: only the issued bit is set.
  - Issue to register 0 with ZERO_REG=1 is ignored.
  - Issue to an already-busy register leaves it busy; no count change.
- Busy outputs: RDx_busy = busy[Rx], masked to 0 when the same-cycle write matches Rx and BYPASS=1, and masked for register 0 when ZERO_REG=1.
- busy_count: registered and updated on the same edge as the busy bits, equal to the popcount of the new busy vector. Saturation is impossible by width (max DEPTH).
- Write with no prior issue is legal; the bit simply stays 0.

Decomposition:
- Shared package regfile_pkg holds the default DATA_W/ADDR_W constants and the encoding of register 0 as a named constant.
- One sub-module, rf_scoreboard, owns the busy vector, priority logic and busy_count. The top holds the storage array, read muxes and bypass.

Test Plan:
- Reset: drive rst_n=0 mid-run after writing reg 5=0x19 -> RD1 (R1=5) = 0 immediately, busy_count = 0; after release, reg 5 reads 0.
- Write/read: RegWrite=1, WR=1, WD=0x24, R2=1 -> with BYPASS=1, RD2=0x24 in the same cycle; with BYPASS=0, RD2=0 before the edge and 0x24 after.
- Zero register: RegWrite=1, WR=0, WD=0x19, then issue_addr=0 -> R1=0 reads 0; RD1_busy=0; busy_count unchanged.
- Scoreboard: issue reg 3 and reg 7 on consecutive edges -> busy_count=2 and RD1_busy=1 for R1=3. Writeback reg 3 -> same-cycle RD1_busy=0 (BYPASS=1); busy_count=1 after the edge.
- Collision: issue_addr=4 and RegWrite WR=4 in the same cycle, with reg 4 busy beforehand -> reg 4 still busy after the edge, busy_count unchanged, mem[4]=WD.
- Flush: 5 registers busy, flush=1 with issue_addr=9 -> after the edge busy_count=1 and only reg 9 is busy.
